alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered decode stage feeding the 32-bit ALU in the RV32I datapath. It accepts one fetched instruction per cycle over a valid/ready handshake and decodes it into the ALU's `ALUOp`/`ALUControl` encoding, register indices, a sign-extended immediate and datapath enables. Results are presented through a two-entry skid buffer, so back-pressure from execute never creates a combinational `in_ready` path. It sits between fetch and the ALU/execute stage.

## Interface
- No parameters (XLEN fixed at 32).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous kill of all buffered entries.
- `in_valid` in 1: fetch has an instruction.
- `in_ready` out 1: stage can accept; driven directly from a register.
- `in_instr` in 32: instruction word.
- `in_pc` in 32: instruction address.
- `out_valid` out 1: decoded entry available.
- `out_ready` in 1: execute accepts.
- `out_pc` out 32: passed-through PC.
- `alu_op` out 3: 000 ld/st, 001 branch, 010 R-type, 011 I-type ALU, 100 JAL.
- `alu_control` out 4: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- `rs1`, `rs2`, `rd` out 5 each: instr[19:15], [24:20], [11:7].
- `imm` out 32: sign-extended immediate (I/S/B/J formats), 0 for R-type.
- `alu_src_imm` out 1: operand B is `imm`.
- `reg_write`, `mem_read`, `mem_write`, `branch`, `jump` out 1 each.
- `illegal` out 1: unsupported encoding.

## Operation
- Opcode 0110011 (R): alu_op 010, reg_write. funct3 000 → ADD (f7 0000000) or SUB (f7 0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA (f7 0/0100000); 110 OR; 111 AND. Any other funct7 → illegal.
- Opcode 0010011 (I-ALU): alu_op 011, alu_src_imm, reg_write, imm = sext(instr[31:20]). Same funct3 map with no SUB. For 001/101, instr[31:25] must be 0000000 (0100000 permitted only with 101, giving SRAI); otherwise illegal.
- Opcode 0000011 (load): alu_op 000, ADD, alu_src_imm, mem_read, reg_write, I-imm.
- Opcode 0100011 (store): alu_op 000, ADD, alu_src_imm, mem_write, S-imm = sext({[31:25],[11:7]}).
- Opcode 1100011 (branch): alu_op 001, branch, B-imm. funct3 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU; 010/011 → illegal.
- Opcode 1101111 (JAL): alu_op 100, ADD, jump, reg_write, J-imm.
- Illegal (any other opcode or bad funct): illegal=1; reg_write, mem_*, branch, jump and alu_src_imm are 0; alu_op 000, ADD; the entry still flows through the handshake.
- Buffer: an output register plus a skid register. `in_ready` = skid empty.
  - An accept with the output empty, or with the output draining the same cycle, loads the output register.
  - An accept while the output is stalled loads the skid register.
  - When the output drains, the skid contents move into the output register.
- Order is strictly preserved. No entry is dropped or duplicated except by flush.

## Timing
- Latency 1: an instruction accepted at edge N is presented with `out_valid`=1 after edge N.
- Throughput: 1 per cycle while `out_ready`=1.
- Reset: `out_valid`=0, `in_ready`=1, all payload outputs 0, skid empty. Reset asserted mid-transfer discards everything.
- Stall: the output holds every payload bit stable while `out_valid && !out_ready`.
- Full (both entries valid): `in_ready`=0 from the next cycle. It returns to 1 the cycle after the first output drain.
- Flush has priority over a simultaneous accept or drain. After the edge, both entries are empty, `out_valid`=0 and `in_ready`=1, and the instruction offered on that edge is dropped.

## Test plan
- 0x002081B3 (add x3,x1,x2) → alu_op 010, ADD, rs1 1, rs2 2, rd 3, reg_write 1, imm 0. Then 0x402081B3 → SUB. Then 0x4020D1B3 → SRA.
- 0xFFF00293 (addi x5,x0,-1) → alu_op 011, ADD, alu_src_imm 1, imm 0xFFFFFFFF, rd 5.
- 0x0020A623 (sw x2,12(x1)) → alu_op 000, ADD, mem_write 1, reg_write 0, imm 12. Then 0x00208463 (beq x1,x2,+8) → alu_op 001, SUB, branch 1, imm 8.
- 0xFFFFFFFF → illegal 1, all enables 0, one output beat, pipeline continues with the next instruction.
- Back-pressure: stream 4 instructions with `out_ready`=0 for 3 cycles.
  - `in_ready` drops after 2 accepts and the output holds the first instruction stable.
  - After release, all 4 emerge in order with no gaps.
- Flush with both entries full and `in_valid`=1 → next cycle `out_valid` 0, `in_ready` 1, and the dropped instruction never appears. Asserting `rst_n`=0 mid-stream gives the same empty state asynchronously.

Source files
------------

// File: rtl/alu_decode_if.sv
// Handshake and payload bundle between fetch, the ALU decode stage and execute.
// Both sides use valid/ready: a beat transfers on a rising edge where valid and ready are both 1.
interface alu_decode_if;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [2:0]  alu_op;
   logic [3:0]  alu_control;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] imm;
   logic        alu_src_imm;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        branch;
   logic        jump;
   logic        illegal;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, alu_op, alu_control, rs1, rs2, rd,
             imm, alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, alu_op, alu_control, rs1, rs2, rd,
             imm, alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal
   );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: turns a fetched instruction into ALU controls, register indices and an
// immediate, presented through an output register backed by one skid register.
module alu_decode_stage (
   input  logic         clk,
   input  logic         rst_n,
   alu_decode_if.slave  bus
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] AOP_MEM    = 3'b000;
   localparam logic [2:0] AOP_BRANCH = 3'b001;
   localparam logic [2:0] AOP_R      = 3'b010;
   localparam logic [2:0] AOP_I      = 3'b011;
   localparam logic [2:0] AOP_JAL    = 3'b100;

   localparam logic [3:0] C_ADD  = 4'b0000;
   localparam logic [3:0] C_SUB  = 4'b0001;
   localparam logic [3:0] C_XOR  = 4'b0010;
   localparam logic [3:0] C_OR   = 4'b0011;
   localparam logic [3:0] C_AND  = 4'b0100;
   localparam logic [3:0] C_SLL  = 4'b0101;
   localparam logic [3:0] C_SRL  = 4'b0110;
   localparam logic [3:0] C_SRA  = 4'b0111;
   localparam logic [3:0] C_SLT  = 4'b1000;
   localparam logic [3:0] C_SLTU = 4'b1001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  alu_op;
      logic [3:0]  alu_control;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        alu_src_imm;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        illegal;
   } dec_t;

   // Shared funct3 -> operation map of R-type and I-type ALU instructions (funct7 default form).
   function automatic logic [3:0] f3_ctrl(input logic [2:0] f3);
      logic [3:0] c;
      case (f3)
         3'b000:  c = C_ADD;
         3'b001:  c = C_SLL;
         3'b010:  c = C_SLT;
         3'b011:  c = C_SLTU;
         3'b100:  c = C_XOR;
         3'b101:  c = C_SRL;
         3'b110:  c = C_OR;
         default: c = C_AND;
      endcase
      return c;
   endfunction

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        bad;
   dec_t        dec;

   assign instr  = bus.in_instr;
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   always_comb begin
      dec             = '0;
      bad             = 1'b0;
      dec.pc          = bus.in_pc;
      dec.rs1         = instr[19:15];
      dec.rs2         = instr[24:20];
      dec.rd          = instr[11:7];
      dec.alu_control = C_ADD;
      case (opcode)
         OP_R: begin
            dec.alu_op    = AOP_R;
            dec.reg_write = 1'b1;
            if (funct7 == F7_BASE)
               dec.alu_control = f3_ctrl(funct3);
            else if (funct7 == F7_ALT && funct3 == 3'b000)
               dec.alu_control = C_SUB;
            else if (funct7 == F7_ALT && funct3 == 3'b101)
               dec.alu_control = C_SRA;
            else
               bad = 1'b1;
         end
         OP_IALU: begin
            dec.alu_op      = AOP_I;
            dec.alu_src_imm = 1'b1;
            dec.reg_write   = 1'b1;
            dec.imm         = {{20{instr[31]}}, instr[31:20]};
            // Shift-immediates reuse the funct7 slot as a qualifier; other funct3 values do not.
            if (funct3 != 3'b001 && funct3 != 3'b101)
               dec.alu_control = f3_ctrl(funct3);
            else if (funct7 == F7_BASE)
               dec.alu_control = f3_ctrl(funct3);
            else if (funct7 == F7_ALT && funct3 == 3'b101)
               dec.alu_control = C_SRA;
            else
               bad = 1'b1;
         end
         OP_LOAD: begin
            dec.alu_op      = AOP_MEM;
            dec.alu_src_imm = 1'b1;
            dec.mem_read    = 1'b1;
            dec.reg_write   = 1'b1;
            dec.imm         = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            dec.alu_op      = AOP_MEM;
            dec.alu_src_imm = 1'b1;
            dec.mem_write   = 1'b1;
            dec.imm         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            dec.alu_op = AOP_BRANCH;
            dec.branch = 1'b1;
            dec.imm    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            case (funct3[2:1])
               2'b00:   dec.alu_control = C_SUB;
               2'b10:   dec.alu_control = C_SLT;
               2'b11:   dec.alu_control = C_SLTU;
               default: bad = 1'b1;
            endcase
         end
         OP_JAL: begin
            dec.alu_op    = AOP_JAL;
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
            dec.imm       = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         default: bad = 1'b1;
      endcase
      // Illegal encodings still travel down the pipe, but must not enable any side effect.
      if (bad) begin
         dec.alu_op      = AOP_MEM;
         dec.alu_control = C_ADD;
         dec.imm         = '0;
         dec.alu_src_imm = 1'b0;
         dec.reg_write   = 1'b0;
         dec.mem_read    = 1'b0;
         dec.mem_write   = 1'b0;
         dec.branch      = 1'b0;
         dec.jump        = 1'b0;
         dec.illegal     = 1'b1;
      end
   end

   dec_t out_q, out_n, skid_q, skid_n;
   logic out_v, out_v_n, skid_v, skid_v_n;
   logic in_ready_q;
   logic accept, drain;

   assign accept = bus.in_valid && in_ready_q;
   assign drain  = out_v && bus.out_ready;

   always_comb begin
      out_n    = out_q;
      out_v_n  = out_v;
      skid_n   = skid_q;
      skid_v_n = skid_v;
      if (bus.flush) begin
         out_v_n  = 1'b0;
         skid_v_n = 1'b0;
      end else if (!out_v || drain) begin
         // in_ready is low while the skid is occupied, so skid refill and accept never collide.
         if (skid_v) begin
            out_n    = skid_q;
            out_v_n  = 1'b1;
            skid_v_n = 1'b0;
         end else if (accept) begin
            out_n   = dec;
            out_v_n = 1'b1;
         end else begin
            out_v_n = 1'b0;
         end
      end else if (accept) begin
         skid_n   = dec;
         skid_v_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= '0;
         out_v      <= 1'b0;
         skid_q     <= '0;
         skid_v     <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         out_q      <= out_n;
         out_v      <= out_v_n;
         skid_q     <= skid_n;
         skid_v     <= skid_v_n;
         in_ready_q <= !skid_v_n;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_v;
   assign bus.out_pc      = out_q.pc;
   assign bus.alu_op      = out_q.alu_op;
   assign bus.alu_control = out_q.alu_control;
   assign bus.rs1         = out_q.rs1;
   assign bus.rs2         = out_q.rs2;
   assign bus.rd          = out_q.rd;
   assign bus.imm         = out_q.imm;
   assign bus.alu_src_imm = out_q.alu_src_imm;
   assign bus.reg_write   = out_q.reg_write;
   assign bus.mem_read    = out_q.mem_read;
   assign bus.mem_write   = out_q.mem_write;
   assign bus.branch      = out_q.branch;
   assign bus.jump        = out_q.jump;
   assign bus.illegal     = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed decode vectors, back-pressure, flush,
// mid-stream reset and a randomized stream checked against an instruction-level model.
module tb_alu_decode_stage;

   localparam int W = 93;

   localparam logic [3:0] C_ADD  = 4'd0;
   localparam logic [3:0] C_SUB  = 4'd1;
   localparam logic [3:0] C_SRA  = 4'd7;
   localparam logic [3:0] C_SLT  = 4'd8;
   localparam logic [3:0] C_SLTU = 4'd9;
   // Operation named by funct3 for R/I ALU instructions: ADD SLL SLT SLTU XOR SRL OR AND.
   localparam logic [3:0] F3_CTRL [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};

   logic clk;
   logic rst_n;

   alu_decode_if bus ();

   alu_decode_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];
   logic [31:0]  src_q[$];
   logic [31:0]  pc_ctr;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model(input logic [31:0] ins, input logic [31:0] pc);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      int         imm_v;
      logic [2:0] aop;
      logic [3:0] ctl;
      logic       src, rw, mr, mw, br, jp, ill;
      op = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[31:25];
      imm_v = 0; aop = 3'd0; ctl = C_ADD;
      src = 0; rw = 0; mr = 0; mw = 0; br = 0; jp = 0; ill = 0;
      case (op)
         7'b0110011: begin
            aop = 3'd2; rw = 1;
            if (f7 == 7'h00) ctl = F3_CTRL[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) ctl = C_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) ctl = C_SRA;
            else ill = 1;
         end
         7'b0010011: begin
            aop = 3'd3; src = 1; rw = 1; imm_v = $signed(ins[31:20]);
            if (f3 == 3'd1 || f3 == 3'd5) begin
               if (f7 == 7'h00) ctl = F3_CTRL[f3];
               else if (f7 == 7'h20 && f3 == 3'd5) ctl = C_SRA;
               else ill = 1;
            end else ctl = F3_CTRL[f3];
         end
         7'b0000011: begin
            src = 1; mr = 1; rw = 1; imm_v = $signed(ins[31:20]);
         end
         7'b0100011: begin
            src = 1; mw = 1; imm_v = $signed({ins[31:25], ins[11:7]});
         end
         7'b1100011: begin
            aop = 3'd1; br = 1;
            imm_v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            if (f3 == 3'd0 || f3 == 3'd1) ctl = C_SUB;
            else if (f3 == 3'd4 || f3 == 3'd5) ctl = C_SLT;
            else if (f3 == 3'd6 || f3 == 3'd7) ctl = C_SLTU;
            else ill = 1;
         end
         7'b1101111: begin
            aop = 3'd4; jp = 1; rw = 1;
            imm_v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
         end
         default: ill = 1;
      endcase
      if (ill) begin
         imm_v = 0; aop = 3'd0; ctl = C_ADD;
         src = 0; rw = 0; mr = 0; mw = 0; br = 0; jp = 0;
      end
      return {pc, aop, ctl, ins[19:15], ins[24:20], ins[11:7], imm_v[31:0],
              src, rw, mr, mw, br, jp, ill};
   endfunction

   function automatic logic [W-1:0] dut_word();
      return {bus.out_pc, bus.alu_op, bus.alu_control, bus.rs1, bus.rs2, bus.rd, bus.imm,
              bus.alu_src_imm, bus.reg_write, bus.mem_read, bus.mem_write, bus.branch,
              bus.jump, bus.illegal};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      ins = $urandom;
      case ($urandom_range(0, 7))
         0: ins[6:0] = 7'b0110011;
         1: ins[6:0] = 7'b0010011;
         2: ins[6:0] = 7'b0000011;
         3: ins[6:0] = 7'b0100011;
         4: ins[6:0] = 7'b1100011;
         5: ins[6:0] = 7'b1101111;
         6: ins[6:0] = 7'b0110011;
         default: ;
      endcase
      case ($urandom_range(0, 3))
         0, 1: ins[31:25] = 7'h00;
         2:    ins[31:25] = 7'h20;
         default: ;
      endcase
      return ins;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   // exp_q holds exactly the entries the stage should be buffering, oldest first.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         chk("in_ready", W'(bus.in_ready), W'(exp_q.size() < 2));
         chk("out_valid", W'(bus.out_valid), W'(exp_q.size() > 0));
         if (bus.out_valid && exp_q.size() > 0)
            chk("payload", dut_word(), exp_q[0]);
         if (bus.flush) begin
            exp_q.delete();
         end else begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0)
               void'(exp_q.pop_front());
            if (bus.in_valid && bus.in_ready)
               exp_q.push_back(model(bus.in_instr, bus.in_pc));
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run(input int max_cyc, input int rdy_low, input bit rnd);
      int c;
      c = 0;
      while (c < max_cyc && (src_q.size() > 0 || exp_q.size() > 0)) begin
         bus.in_valid  = (src_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
         bus.in_instr  = (src_q.size() > 0) ? src_q[0] : 32'h0;
         bus.in_pc     = pc_ctr;
         bus.out_ready = (c >= rdy_low) && (!rnd || $urandom_range(0, 9) < 7);
         bus.flush     = rnd && ($urandom_range(0, 39) == 0);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready && !bus.flush) begin
            void'(src_q.pop_front());
            pc_ctr = pc_ctr + 32'd4;
         end
         @(posedge clk);
         #1;
         c++;
      end
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      checks++;
      if (src_q.size() > 0 || exp_q.size() > 0) begin
         failures++;
         $display("FAIL run_timeout pending_src=%0d pending_exp=%0d required=0", src_q.size(),
                  exp_q.size());
         src_q.delete();
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.in_pc     = 32'h0;
      bus.out_ready = 1'b1;
      pc_ctr        = 32'h0000_1000;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_payload", dut_word(), '0);
      chk("reset_flags", W'({bus.out_valid, bus.in_ready}), W'(2'b01));
      rst_n = 1'b1;

      // Directed decode vectors flowing with no back-pressure.
      src_q = '{32'h002081B3, 32'h402081B3, 32'h4020D1B3, 32'hFFF00293,
                32'h0020A623, 32'h00208463, 32'hFFFFFFFF, 32'h00000013};
      run(60, 0, 1'b0);

      // Back-pressure: four instructions, execute stalled for three cycles.
      src_q = '{32'h00C58533, 32'h40B50533, 32'h0FF00093, 32'hFE0008E3};
      run(60, 3, 1'b0);

      // Flush with both entries full and a third instruction offered.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'h00100093;
      bus.in_pc     = pc_ctr;
      @(posedge clk); #1;
      bus.in_instr  = 32'h00200113;
      bus.in_pc     = pc_ctr + 32'd4;
      @(posedge clk); #1;
      chk("full_in_ready", W'(bus.in_ready), W'(1'b0));
      bus.in_instr  = 32'h00500313;
      bus.in_pc     = pc_ctr + 32'd8;
      bus.flush     = 1'b1;
      @(posedge clk); #1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      chk("flush_state", W'({bus.out_valid, bus.in_ready}), W'(2'b01));
      pc_ctr = pc_ctr + 32'd16;
      src_q  = '{32'h00700393};
      run(20, 0, 1'b0);

      // Asynchronous reset in the middle of a stalled stream.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'h008001EF;
      bus.in_pc     = pc_ctr;
      @(posedge clk); #1;
      bus.in_instr  = 32'h0042A283;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset_payload", dut_word(), '0);
      chk("async_reset_flags", W'({bus.out_valid, bus.in_ready}), W'(2'b01));
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;

      // Randomized stream with random stalls, bubbles and occasional flushes.
      for (int i = 0; i < 600; i++) src_q.push_back(rand_instr());
      run(20000, 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
